// File: rtl/led_pulse_stretcher_pkg.sv
// led_pulse_stretcher_pkg: shared state encoding and timer sizing for the LED pulse stretcher.
package led_pulse_stretcher_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } state_t;

    function automatic int timer_width(input int on_cycles, input int off_cycles);
        return $clog2((on_cycles > off_cycles ? on_cycles : off_cycles) + 1);
    endfunction

endpackage

// File: rtl/led_pulse_stretcher_if.sv
// led_pulse_stretcher_if: event strobe in, LED drive and status out.
interface led_pulse_stretcher_if #(
    parameter int PEND_WIDTH = 4
);
    logic                  evt;
    logic                  led;
    logic                  busy;
    logic [PEND_WIDTH-1:0] pending;
    logic                  dropped;

    modport master (output evt, input led, busy, pending, dropped);
    modport slave  (input evt, output led, busy, pending, dropped);
endinterface

// File: rtl/led_pulse_stretcher.sv
// led_pulse_stretcher: turns single-cycle events into distinct LED flashes with a minimum
// on-time and off-gap, queueing events that arrive mid-flash.
module led_pulse_stretcher
    import led_pulse_stretcher_pkg::*;
#(
    parameter int ON_CYCLES  = 12500000,
    parameter int OFF_CYCLES = 12500000,
    parameter int PEND_WIDTH = 4
) (
    input logic clk,
    input logic rst_n,
    led_pulse_stretcher_if.slave bus
);
    localparam int TW = timer_width(ON_CYCLES, OFF_CYCLES);
    localparam logic [TW-1:0] T_ON  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] T_OFF = TW'(OFF_CYCLES - 1);
    localparam logic [PEND_WIDTH-1:0] P_MAX = '1;

    state_t state, state_nx;
    logic [TW-1:0] timer, timer_nx;
    logic [PEND_WIDTH-1:0] pending, pending_nx;
    logic dropped, dropped_nx, led;
    logic last, gap_end, queue_evt, restart;

    assign last      = timer == '0;
    assign gap_end   = state == GAP && last;
    // the last GAP cycle hands a fresh event straight to the next flash instead of queueing it
    assign queue_evt = bus.evt && state != IDLE && !gap_end;
    assign restart   = pending != '0 || bus.evt;

    always_comb begin
        state_nx   = state;
        timer_nx   = timer;
        pending_nx = pending;
        dropped_nx = dropped;
        case (state)
            IDLE: begin
                state_nx = bus.evt ? ON : IDLE;
                timer_nx = bus.evt ? T_ON : '0;
            end
            ON: begin
                state_nx = last ? GAP : ON;
                timer_nx = last ? T_OFF : timer - 1'b1;
            end
            GAP: begin
                state_nx = last ? (restart ? ON : IDLE) : GAP;
                timer_nx = last ? (restart ? T_ON : '0) : timer - 1'b1;
            end
            default: begin
                state_nx = IDLE;
                timer_nx = '0;
            end
        endcase
        if (queue_evt && pending == P_MAX)
            dropped_nx = 1'b1;
        else if (queue_evt)
            pending_nx = pending + 1'b1;
        else if (gap_end && pending != '0 && !bus.evt)
            pending_nx = pending - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            timer   <= '0;
            pending <= '0;
            dropped <= 1'b0;
            led     <= 1'b0;
        end else begin
            state   <= state_nx;
            timer   <= timer_nx;
            pending <= pending_nx;
            dropped <= dropped_nx;
            led     <= state_nx == ON;
        end
    end

    assign bus.led     = led;
    assign bus.busy    = state != IDLE;
    assign bus.pending = pending;
    assign bus.dropped = dropped;
endmodule

// File: tb/tb_led_pulse_stretcher.sv
// tb_led_pulse_stretcher: directed and random checks against a flash-schedule reference model.
module tb_led_pulse_stretcher;
    localparam int ON   = 4;
    localparam int OFF  = 3;
    localparam int PW   = 2;
    localparam int PMAX = (1 << PW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rises = 0;
    logic prev_led = 1'b0;

    // reference: a flash is a window of ON+OFF cycles; pos is the offset inside it
    bit m_act;
    int m_pos;
    int m_pend;
    bit m_drop;

    led_pulse_stretcher_if #(.PEND_WIDTH(PW)) bus ();

    led_pulse_stretcher #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .PEND_WIDTH(PW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_act = 0;
        m_pos = 0;
        m_pend = 0;
        m_drop = 0;
    endtask

    task automatic model_edge(input bit e);
        if (!m_act) begin
            if (e) begin
                m_act = 1;
                m_pos = 0;
            end
        end else if (m_pos == ON + OFF - 1) begin
            if (m_pend > 0) begin
                m_pos = 0;
                if (!e) m_pend--;
            end else if (e) m_pos = 0;
            else m_act = 0;
        end else begin
            m_pos++;
            if (e) begin
                if (m_pend == PMAX) m_drop = 1;
                else m_pend++;
            end
        end
    endtask

    task automatic check_all();
        chk("led", 32'(bus.led), 32'(m_act && m_pos < ON));
        chk("busy", 32'(bus.busy), 32'(m_act));
        chk("pending", 32'(bus.pending), 32'(m_pend));
        chk("dropped", 32'(bus.dropped), 32'(m_drop));
    endtask

    task automatic step(input bit e);
        bus.evt = e;
        @(posedge clk);
        model_edge(e);
        cyc++;
        @(negedge clk);
        check_all();
        if (bus.led && !prev_led) rises++;
        prev_led = bus.led;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        prev_led = 1'b0;
    endtask

    initial begin
        logic [7:0] ledv;
        logic [7:0] busyv;
        bus.evt = 1'b0;
        model_reset();
        @(negedge clk);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // idle after reset: nothing may move
        idle(50);

        // single event: 4 on, 3 off, idle after 8 edges
        for (int i = 0; i < 8; i++) begin
            step(i == 0);
            ledv[i] = bus.led;
            busyv[i] = bus.busy;
        end
        chk("s1_led_pattern", 32'(ledv), 32'h0F);
        chk("s1_busy_pattern", 32'(busyv), 32'h7F);
        idle(3);

        // three back-to-back events replay as three flashes
        rises = 0;
        step(1); step(1); step(1);
        chk("s2_pending", 32'(bus.pending), 32'd2);
        idle(25);
        chk("s2_flashes", 32'(rises), 32'd3);

        // held event saturates the queue and latches dropped
        rises = 0;
        for (int i = 0; i < 6; i++) step(1);
        chk("s3_dropped", 32'(bus.dropped), 32'd1);
        idle(35);
        chk("s3_flashes", 32'(rises), 32'd4);
        chk("s3_dropped_sticky", 32'(bus.dropped), 32'd1);

        // event on the last gap cycle with one queued, then with none
        step(1); step(1); idle(5); step(1);
        chk("s4a_pending", 32'(bus.pending), 32'd1);
        chk("s4a_led", 32'(bus.led), 32'd1);
        idle(20);
        step(1); idle(6); step(1);
        chk("s4b_pending", 32'(bus.pending), 32'd0);
        chk("s4b_led", 32'(bus.led), 32'd1);
        idle(10);

        // asynchronous reset mid-flash, then a clean single flash
        step(1); step(0);
        chk("s5_led_before", 32'(bus.led), 32'd1);
        pulse_reset();
        idle(2);
        step(1);
        chk("s5_latency", 32'(bus.led), 32'd1);
        idle(10);

        // random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) pulse_reset();
            else step($urandom_range(0, 3) == 0);
        end
        idle(30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
